// File: rtl/mips_cp0_ext_if.sv
// Bus between the M stage / NPC and the extended coprocessor 0.
// Signal names follow the pipeline's existing CP0 port names.
interface mips_cp0_ext_if #(
  parameter int N_HWINT = 6
);
  logic               i_en;
  logic [4:0]         i_CP0Addr;
  logic [31:0]        i_CP0In;
  logic [31:0]        i_VPC;
  logic               i_BDIn;
  logic [4:0]         i_ExcCodeIn;
  logic [N_HWINT-1:0] i_HWInt;
  logic               i_EXLClr;
  logic [31:0]        o_EPCOut;
  logic [31:0]        o_CP0Out;
  logic               o_Req;
  logic [3:0]         o_IntNo;

  modport master (
    output i_en, i_CP0Addr, i_CP0In, i_VPC, i_BDIn, i_ExcCodeIn, i_HWInt, i_EXLClr,
    input  o_EPCOut, o_CP0Out, o_Req, o_IntNo
  );

  modport slave (
    input  i_en, i_CP0Addr, i_CP0In, i_VPC, i_BDIn, i_ExcCodeIn, i_HWInt, i_EXLClr,
    output o_EPCOut, o_CP0Out, o_Req, o_IntNo
  );
endinterface

// File: rtl/mips_cp0_ext.sv
// Parametrised CP0: SR/Cause/EPC/PrId/Count/Compare, level or edge interrupt
// lines, Count/Compare timer and a priority-encoded interrupt number.
module mips_cp0_ext #(
  parameter int                 N_HWINT    = 6,
  parameter logic [N_HWINT-1:0] EDGE_MASK  = '0,
  parameter int                 TIMER_LINE = N_HWINT - 1,
  parameter logic [31:0]        EPC_RESET  = 32'h0000_0000,
  parameter logic [31:0]        PRID       = 32'h2004_1023
) (
  input  logic           i_clk,
  input  logic           i_reset,
  mips_cp0_ext_if.slave  bus
);
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  logic [N_HWINT-1:0] im_q, im_d, ip_q, ip_d, prev_q, prev_d, latch_q, latch_d;
  logic               exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, ti_q, ti_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [31:0]        epc_q, epc_d, count_q, count_d, compare_q, compare_d;

  logic [N_HWINT-1:0] eff, eff_en;
  logic               int_req, exc_req, req, wr;
  logic [3:0]         int_no;
  logic [31:0]        epc_new, epc_wdata, epc_fwd, sr_rd, cause_rd, rd_data;

  // Pending lines, request generation and lowest-index priority encode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    eff    = '0;
    int_no = '0;
    for (int k = 0; k < N_HWINT; k++) begin
      eff[k] = (EDGE_MASK[k] ? latch_q[k] : bus.i_HWInt[k]) | ((k == TIMER_LINE) && ti_q);
    end
    eff_en  = eff & im_q;
    int_req = ~i_reset & ~exl_q & ie_q & (|eff_en);
    exc_req = ~i_reset & ~exl_q & (bus.i_ExcCodeIn != 5'd0);
    req     = int_req | exc_req;
    if (int_req) begin
      for (int k = N_HWINT - 1; k >= 0; k--) begin
        if (eff_en[k]) int_no = 4'(k);
      end
    end
  end

  // A request swallows any mtc0 of the same cycle; EPC is forwarded to NPC.
  always_comb begin
    wr        = bus.i_en & ~req;
    epc_new   = bus.i_BDIn ? bus.i_VPC - 32'd4 : bus.i_VPC;
    epc_wdata = {bus.i_CP0In[31:2], 2'b00};
    if (req)                                  epc_fwd = epc_new;
    else if (wr && bus.i_CP0Addr == REG_EPC)  epc_fwd = epc_wdata;
    else                                      epc_fwd = epc_q;

    sr_rd                   = '0;
    sr_rd[10 +: N_HWINT]    = im_q;
    sr_rd[1]                = exl_q;
    sr_rd[0]                = ie_q;
    cause_rd                = '0;
    cause_rd[31]            = bd_q;
    cause_rd[30]            = ti_q;
    cause_rd[10 +: N_HWINT] = ip_q;
    cause_rd[6:2]           = exc_code_q;

    case (bus.i_CP0Addr)
      REG_COUNT:   rd_data = count_q;
      REG_COMPARE: rd_data = compare_q;
      REG_SR:      rd_data = sr_rd;
      REG_CAUSE:   rd_data = cause_rd;
      REG_EPC:     rd_data = epc_fwd;
      REG_PRID:    rd_data = PRID;
      default:     rd_data = '0;
    endcase
  end

  // Next-state for all architectural registers.
  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    compare_d  = compare_q;
    count_d    = count_q + 32'd1;
    ip_d       = eff;
    prev_d     = bus.i_HWInt;
    latch_d    = latch_q;

    if (wr && bus.i_CP0Addr == REG_SR) begin
      im_d  = bus.i_CP0In[10 +: N_HWINT];
      exl_d = bus.i_CP0In[1];
      ie_d  = bus.i_CP0In[0];
    end
    if (bus.i_EXLClr) exl_d = 1'b0;
    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bus.i_BDIn;
      exc_code_d = int_req ? 5'd0 : bus.i_ExcCodeIn;
      epc_d      = epc_new;
    end else if (wr && bus.i_CP0Addr == REG_EPC) begin
      epc_d = epc_wdata;
    end

    if (wr && bus.i_CP0Addr == REG_COUNT)   count_d   = bus.i_CP0In;
    if (wr && bus.i_CP0Addr == REG_COMPARE) compare_d = bus.i_CP0In;
    // A Compare write clears TI even on the cycle the match would set it.
    ti_d = (wr && bus.i_CP0Addr == REG_COMPARE) ? 1'b0 :
           (count_q == compare_q) ? 1'b1 : ti_q;

    for (int k = 0; k < N_HWINT; k++) begin
      if (EDGE_MASK[k]) begin
        if (wr && bus.i_CP0Addr == REG_CAUSE && bus.i_CP0In[10+k]) latch_d[k] = 1'b0;
        if (bus.i_HWInt[k] && !prev_q[k])                          latch_d[k] = 1'b1;
      end else begin
        latch_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      im_q       <= '0;
      ip_q       <= '0;
      prev_q     <= '0;
      latch_q    <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= EPC_RESET;
      count_q    <= '0;
      compare_q  <= 32'hFFFF_FFFF;
    end else begin
      im_q       <= im_d;
      ip_q       <= ip_d;
      prev_q     <= prev_d;
      latch_q    <= latch_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
    end
  end

  assign bus.o_Req    = req;
  assign bus.o_IntNo  = int_no;
  assign bus.o_EPCOut = epc_fwd;
  assign bus.o_CP0Out = rd_data;
endmodule

// File: doc/mips_cp0_ext.md
# mips_cp0_ext

Parametrised coprocessor-0 for the MIPS pipeline, replacing the fixed six-line CP0. It adds:
- a configurable number of hardware interrupt lines, each independently level- or edge-sensitive (edge lines latched until software clears them);
- a Count/Compare timer that raises an internal interrupt;
- a priority-encoded interrupt number output.

It sits beside the M stage: it takes mtc0/mfc0 traffic, exception codes and the victim PC, and drives the request and EPC to NPC.

## Interface
- N_HWINT, 6, number of hardware interrupt lines, 1..16; IM/IP occupy bits [10+N_HWINT-1:10]
- EDGE_MASK, {N_HWINT{1'b0}}, bit k = 1 makes line k edge-sensitive (latched), 0 = level
- TIMER_LINE, N_HWINT-1, interrupt line onto which the timer interrupt TI is ORed
- EPC_RESET, 32'h0000_0000, EPC reset value
- PRID, 32'h2004_1023, read-only processor ID

- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_en  in  1  mtc0 write enable
- i_CP0Addr  in  5  CP0 register number for mtc0/mfc0
- i_CP0In  in  32  mtc0 write data
- i_VPC  in  32  victim PC
- i_BDIn  in  1  victim is in a branch delay slot
- i_ExcCodeIn  in  5  exception code, 0 = none
- i_HWInt  in  N_HWINT  external interrupt lines
- i_EXLClr  in  1  eret: clear EXL
- o_EPCOut  out  32  EPC value to NPC (forwarded)
- o_CP0Out  out  32  mfc0 read data
- o_Req  out  1  enter handler
- o_IntNo  out  4  lowest-index pending enabled line; 0 when no interrupt request

## Operation
- Registers and fields:
  - SR (12): only IM, EXL[1] and IE[0] are stored; all other bits read 0.
  - Cause (13): BD[31], TI[30], IP, ExcCode[6:2]; other bits read 0.
  - EPC (14): read/write, bits [1:0] forced 0 on write.
  - PrId (15): read-only, returns PRID.
  - Count (9): read/write, +1 every cycle, wraps FFFF_FFFF→0.
  - Compare (11): read/write.
- Edge latching:
  - prev[k] holds the registered i_HWInt.
  - latch[k] is set when i_HWInt[k] & ~prev[k] and EDGE_MASK[k].
- Effective pending:
  - eff[k] = (EDGE_MASK[k] ? latch[k] : i_HWInt[k]) | (k==TIMER_LINE & TI).
  - Cause.IP <= eff every cycle (registered, one cycle behind eff).
- Timer: TI is set on the clock edge where Count==Compare. Any mtc0 write to Compare clears TI.
- Cause write (mtc0 13): writing 1 to an IP bit of an edge line clears its latch (W1C). All other Cause bits are read-only.
- Requests:
  - IntReq = !EXL & IE & |(eff & IM).
  - ExcReq = !EXL & (i_ExcCodeIn != 0).
  - o_Req = IntReq | ExcReq.
  - o_IntNo = lowest k with eff[k]&IM[k] when IntReq.
- On o_Req:
  - EXL<=1, BD<=i_BDIn.
  - ExcCode <= IntReq ? 0 : i_ExcCodeIn; interrupt wins over exception.
  - EPC <= i_BDIn ? i_VPC-4 : i_VPC.
  - Any mtc0 in the same cycle is discarded.
- i_EXLClr clears EXL. If o_Req is also high, EXL=1 wins.
- o_EPCOut priority:
  1. the new EPC if o_Req;
  2. else {i_CP0In[31:2],2'b00} if an mtc0 to 14 is in the same cycle;
  3. else EPC.
- o_CP0Out is combinational on i_CP0Addr. Address 14 returns o_EPCOut; any other unmapped address returns 0.

## Timing
- Reset values (synchronous, one cycle):
  - SR, Cause, Count, prev, latch: 0.
  - Compare: FFFF_FFFF.
  - EPC: EPC_RESET.
  - Outputs: o_Req=0, o_IntNo=0, o_CP0Out=0 unless the address selects PrId/EPC/Compare.
- Reset asserted mid-handler clears EXL and all pending latches; edges seen during reset are not latched.
- mtc0 writes are visible on mfc0 the next cycle, except EPC, which is forwarded the same cycle.
- Count write and increment in the same cycle: the written value is stored; it increments from the following cycle.
- Count==Compare and a Compare write in the same cycle: the write's TI clear wins.
- Edge rising and W1C of the same line in the same cycle: set wins.
- Interrupt sampled at cycle t is seen at o_Req in the same cycle t (combinational). EXL blocks further requests from t+1.
- An edge on line k at cycle t sets latch at t+1; o_Req rises at t+1 if enabled.

## Test plan
- Reset, then SR=0x0000_0401 (IM[0]=1, IE=1), level i_HWInt=6'b000001, VPC=0x3000, BD=0:
  - o_Req=1, o_IntNo=0, o_EPCOut=0x3000;
  - next cycle Cause.ExcCode=0, EXL=1, o_Req=0 while the line stays high.
- ExcCode=5'd12 with an enabled interrupt simultaneously, BD=1, VPC=0x3008: ExcCode=0, EPC=0x3004, BD=1.
- EDGE_MASK[2]=1, one-cycle pulse on line 2, IE=0:
  - IP[12] stays 1 after the pulse;
  - setting IE=1 gives o_Req;
  - after eret, mtc0 Cause with 0x0000_1000 clears it and IP[12]=0.
- Compare=5 written at Count=0, IM on TIMER_LINE, IE=1: TI=1 and o_Req when Count passes 5; writing Compare clears TI.
- Lines 1 and 3 both pending and enabled: o_IntNo=1; masking IM[1] gives o_IntNo=3.
- mtc0 EPC=0x3103 with o_Req=0: o_EPCOut=0x3100 the same cycle. With o_Req=1 in the same cycle, the write is dropped.
